// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage ARM pipeline: operand forwarding, stall/flush generation,
// a data-memory wait watchdog and saturating stall/flush event counters.
module hazard_unit #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8      // must be >= 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             CntClear,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} wait_state_t;

    wait_state_t      state_reg, state_next;
    logic [WW-1:0]    wait_cnt_reg, wait_cnt_next;
    logic             timeout_reg;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic             ldr_stall, mem_stall, timeout_hit;

    logic [3:0] src_e   [2];
    logic [1:0] fwd_sel [2];

    assign ldr_stall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
    assign mem_stall = MemReqM & ~MemReadyM;

    assign src_e[0] = RA1E;
    assign src_e[1] = RA2E;

    // R15 reads as PC+8 in Execute, so it is never a forwarding target.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] = (src_e[gi] == 4'hF)                   ? 2'b00 :
                             (RegWriteM && (src_e[gi] == WA3M))    ? 2'b10 :
                             (RegWriteW && (src_e[gi] == WA3W))    ? 2'b01 : 2'b00;
    end

    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

    always_comb begin
        StallF = ldr_stall | PCWrPendingF;
        StallD = ldr_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
        FlushE = ldr_stall | BranchTakenE;
        FlushW = 1'b0;
        // Freeze everything while memory is busy; control hazards resolve on release.
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_stall) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WW'(1);
                end
            end
            ST_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt_reg != WAIT_MAX)
                        wait_cnt_next = wait_cnt_reg + WW'(1);
                end else begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Fires only on the step into MAX_WAIT, not while the count sits saturated.
    assign timeout_hit = mem_stall && (wait_cnt_next == WAIT_MAX) && (wait_cnt_reg != WAIT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (CntClear) begin
                timeout_reg   <= 1'b0;
                stall_cnt_reg <= '0;
                flush_cnt_reg <= '0;
            end else begin
                if (timeout_hit)
                    timeout_reg <= 1'b1;
                if (StallD && (stall_cnt_reg != '1))
                    stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
                if (BranchTakenE && !mem_stall && (flush_cnt_reg != '1))
                    flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign MemTimeout = timeout_reg;
    assign StallCount = stall_cnt_reg;
    assign FlushCount = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: hand-computed vector table, directed multi-cycle
// sequences (memory wait, timeout, saturation, async reset) and randomized model checks.
module tb_hazard_unit;
    localparam int CW   = 4;
    localparam int MAXW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE;
    logic MemReqM, MemReadyM, CntClear;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [CW-1:0] StallCount, FlushCount;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(CW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClear(CntClear),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    typedef struct packed {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic rwm, rww, mtre, pcwp, pcsrcw, bte, mreq, mrdy;
    } in_t;

    // st = {StallF,StallD,StallE,StallM}, fl = {FlushD,FlushE,FlushW}
    typedef struct packed {
        logic [1:0] fa, fb;
        logic [3:0] st;
        logic [2:0] fl;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: counts of events and the length of the current memory-wait run.
    int m_stall = 0, m_flush = 0, m_run = 0;
    bit m_tmo = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(logic [3:0] src, in_t x);
        if (src == 4'd15) return 2'b00;
        if (x.rwm && src == x.wa3m) return 2'b10;
        if (x.rww && src == x.wa3w) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t model_comb(in_t x);
        out_t r;
        bit ldr, ms;
        ldr  = x.mtre && (x.ra1d == x.wa3e || x.ra2d == x.wa3e);
        ms   = x.mreq && !x.mrdy;
        r.fa = fwd_ref(x.ra1e, x);
        r.fb = fwd_ref(x.ra2e, x);
        if (ms) begin
            r.st = 4'b1111;
            r.fl = 3'b001;
        end else begin
            r.st = {ldr | x.pcwp, ldr, 2'b00};
            r.fl = {x.pcwp | x.pcsrcw | x.bte, ldr | x.bte, 1'b0};
        end
        return r;
    endfunction

    task automatic model_seq(in_t x, bit clr);
        bit ms, ldr;
        int prev;
        ms   = x.mreq && !x.mrdy;
        ldr  = x.mtre && (x.ra1d == x.wa3e || x.ra2d == x.wa3e);
        prev = m_run;
        m_run = ms ? ((m_run < MAXW) ? m_run + 1 : MAXW) : 0;
        if (clr) begin
            m_stall = 0;
            m_flush = 0;
            m_tmo   = 1'b0;
        end else begin
            if (ldr || ms) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (x.bte && !ms) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (ms && prev < MAXW && m_run == MAXW) m_tmo = 1'b1;
        end
    endtask

    task automatic drive(in_t x, bit clr);
        RA1D = x.ra1d; RA2D = x.ra2d; RA1E = x.ra1e; RA2E = x.ra2e;
        WA3E = x.wa3e; WA3M = x.wa3m; WA3W = x.wa3w;
        RegWriteM = x.rwm; RegWriteW = x.rww; MemtoRegE = x.mtre;
        PCWrPendingF = x.pcwp; PCSrcW = x.pcsrcw; BranchTakenE = x.bte;
        MemReqM = x.mreq; MemReadyM = x.mrdy; CntClear = clr;
    endtask

    function automatic out_t act_out();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic chk_seq(string nm);
        chk({nm, ":stall_cnt"}, 64'(StallCount), 64'(m_stall));
        chk({nm, ":flush_cnt"}, 64'(FlushCount), 64'(m_flush));
        chk({nm, ":timeout"},   64'(MemTimeout), 64'(m_tmo));
    endtask

    // Called just after a rising edge; leaves time just after the next rising edge.
    task automatic step(string nm, in_t x, bit clr, bit use_exp, out_t exp);
        out_t e;
        drive(x, clr);
        #1;
        e = use_exp ? exp : model_comb(x);
        chk({nm, ":comb"}, 64'(act_out()), 64'(e));
        @(posedge clk);
        model_seq(x, clr);
        #1;
        chk_seq(nm);
        $display("%-12s in=%h clr=%0b fa=%b fb=%b st=%b%b%b%b fl=%b%b%b sc=%0d fc=%0d tmo=%b",
                 nm, x, clr, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                 FlushD, FlushE, FlushW, StallCount, FlushCount, MemTimeout);
    endtask

    function automatic in_t base_in();
        in_t b;
        b = '0;
        b.ra1d = 4'd1; b.ra2d = 4'd2; b.ra1e = 4'd3; b.ra2e = 4'd4;
        b.wa3e = 4'd6; b.wa3m = 4'd7; b.wa3w = 4'd8;
        return b;
    endfunction

    function automatic vec_t mk(string n, in_t i, logic [1:0] fa, logic [1:0] fb,
                                logic [3:0] st, logic [2:0] fl);
        vec_t v;
        v.name = n; v.i = i;
        v.o.fa = fa; v.o.fb = fb; v.o.st = st; v.o.fl = fl;
        return v;
    endfunction

    function automatic logic [3:0] rreg();
        if ($urandom_range(0, 7) == 0) return 4'hF;
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[$];
        in_t  x, z, ms_in;
        out_t nul;

        nul = '0;
        z   = '0;

        // Reset state with all inputs low.
        reset = 1'b0;
        drive(z, 1'b0);
        #2;
        chk("reset:comb", 64'(act_out()), 64'(0));
        chk_seq("reset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Hand-computed vector table.
        x = base_in();                                                vt.push_back(mk("idle", x, 2'b00, 2'b00, 4'b0000, 3'b000));
        x = base_in(); x.wa3m = 3; x.rwm = 1; x.wa3w = 3; x.rww = 1;  vt.push_back(mk("fwdA_M", x, 2'b10, 2'b00, 4'b0000, 3'b000));
        x.rwm = 0;                                                    vt.push_back(mk("fwdA_W", x, 2'b01, 2'b00, 4'b0000, 3'b000));
        x = base_in(); x.ra1e = 15; x.wa3m = 15; x.wa3w = 15; x.rwm = 1; x.rww = 1;
                                                                      vt.push_back(mk("fwdA_r15", x, 2'b00, 2'b00, 4'b0000, 3'b000));
        x = base_in(); x.ra2e = 9; x.wa3m = 9; x.rwm = 1;             vt.push_back(mk("fwdB_M", x, 2'b00, 2'b10, 4'b0000, 3'b000));
        x = base_in(); x.ra1e = 10; x.ra2e = 10; x.wa3w = 10; x.rww = 1; x.wa3m = 11; x.rwm = 1;
                                                                      vt.push_back(mk("fwdAB_W", x, 2'b01, 2'b01, 4'b0000, 3'b000));
        x = base_in(); x.mtre = 1; x.wa3e = 5; x.ra2d = 5;            vt.push_back(mk("ldr_use", x, 2'b00, 2'b00, 4'b1100, 3'b010));
        x = base_in(); x.bte = 1;                                     vt.push_back(mk("branch", x, 2'b00, 2'b00, 4'b0000, 3'b110));
        x = base_in(); x.pcwp = 1;                                    vt.push_back(mk("pc_pend", x, 2'b00, 2'b00, 4'b1000, 3'b100));
        x = base_in(); x.pcsrcw = 1;                                  vt.push_back(mk("pcsrc_w", x, 2'b00, 2'b00, 4'b0000, 3'b100));
        x = base_in(); x.mreq = 1; x.bte = 1; x.mtre = 1; x.wa3e = 1; vt.push_back(mk("mem_stall", x, 2'b00, 2'b00, 4'b1111, 3'b001));
        x = base_in(); x.mreq = 1; x.mrdy = 1; x.bte = 1;             vt.push_back(mk("mem_ready", x, 2'b00, 2'b00, 4'b0000, 3'b110));

        foreach (vt[k]) step(vt[k].name, vt[k].i, 1'b0, 1'b1, vt[k].o);

        // Memory wait holding a taken branch, then release.
        step("clr", z, 1'b1, 1'b0, nul);
        x = base_in(); x.mreq = 1; x.bte = 1;
        for (int i = 0; i < 3; i++) step("memwait_br", x, 1'b0, 1'b1, out_t'{2'b00, 2'b00, 4'b1111, 3'b001});
        x.mrdy = 1;
        step("memrel_br", x, 1'b0, 1'b1, out_t'{2'b00, 2'b00, 4'b0000, 3'b110});
        chk("memrel_br:flush_cnt_const", 64'(FlushCount), 64'(1));

        // Timeout after MAX_WAIT consecutive wait cycles; sticky until CntClear.
        step("clr", z, 1'b1, 1'b0, nul);
        x = base_in(); x.mreq = 1;
        for (int i = 1; i <= 10; i++) begin
            step("timeout", x, 1'b0, 1'b0, nul);
            chk("timeout:edge_const", 64'(MemTimeout), 64'(i >= MAXW));
        end
        x.mrdy = 1;
        step("tmo_hold", x, 1'b0, 1'b0, nul);
        chk("tmo_hold:const", 64'(MemTimeout), 64'(1));
        step("tmo_clr", z, 1'b1, 1'b0, nul);
        chk("tmo_clr:const", 64'(MemTimeout), 64'(0));

        // Stall counter saturation under a long load-use hazard.
        x = base_in(); x.mtre = 1; x.wa3e = 5; x.ra1d = 5;
        for (int i = 0; i < 20; i++) step("sat", x, 1'b0, 1'b0, nul);
        chk("sat:const", 64'(StallCount), 64'(15));

        // Asynchronous reset in the middle of a memory wait with a load-use pending.
        ms_in = x; ms_in.mreq = 1;
        for (int i = 0; i < 5; i++) step("pre_rst", ms_in, 1'b0, 1'b0, nul);
        #2;
        reset = 1'b0;
        #1;
        m_stall = 0; m_flush = 0; m_run = 0; m_tmo = 1'b0;
        chk_seq("mid_rst");
        chk("mid_rst:comb", 64'(act_out()), 64'(out_t'{2'b00, 2'b00, 4'b1111, 3'b001}));
        drive(z, 1'b0);
        #1;
        chk("mid_rst:zero", 64'(act_out()), 64'(0));
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        model_seq(z, 1'b0);
        #1;
        for (int i = 1; i <= MAXW; i++) begin
            step("post_rst", ms_in, 1'b0, 1'b0, nul);
            chk("post_rst:tmo_const", 64'(MemTimeout), 64'(i == MAXW));
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            x.ra1d = rreg(); x.ra2d = rreg(); x.ra1e = rreg(); x.ra2e = rreg();
            x.wa3e = rreg(); x.wa3m = rreg(); x.wa3w = rreg();
            x.rwm = 1'($urandom_range(0, 1)); x.rww = 1'($urandom_range(0, 1));
            x.mtre = 1'($urandom_range(0, 1));
            x.pcwp = ($urandom_range(0, 3) == 0); x.pcsrcw = ($urandom_range(0, 3) == 0);
            x.bte = 1'($urandom_range(0, 1));
            x.mreq = ($urandom_range(0, 3) != 0); x.mrdy = ($urandom_range(0, 4) == 0);
            step("rand", x, ($urandom_range(0, 15) == 0), 1'b0, nul);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Responder side of the controller's hazard interface in the 5-stage pipelined ARM core.
- Consumes RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW and BranchTakenE together with the register addresses of each stage.
- Produces forwarding selects, per-stage stalls and flushes (FlushE returns to the controller).
- Adds a data-memory wait FSM with timeout detection and saturating stall/flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of each event counter.
- MAX_WAIT, 8, consecutive memory-wait cycles after which MemTimeout is set.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  4 each  source registers in Decode
- RA1E, RA2E  in  4 each  source registers in Execute
- WA3E, WA3M, WA3W  in  4 each  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1 each  gated register writes from the controller
- MemtoRegE  in  1  load in Execute
- PCWrPendingF  in  1  PC write pending in D/E/M
- PCSrcW  in  1  PC write in Writeback
- BranchTakenE  in  1  branch resolved taken in Execute
- MemReqM  in  1  data-memory access in Memory (MemWriteM or MemtoRegM)
- MemReadyM  in  1  data memory completes the access this cycle
- CntClear  in  1  synchronous clear of the counters and MemTimeout
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = ResultW, 10 = ALUResultM
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register
- FlushD, FlushE, FlushW  out  1 each  bubble the stage register
- MemTimeout  out  1  sticky wait-timeout flag
- StallCount, FlushCount  out  CNT_W each  event counters

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if (RA1E == WA3M) & RegWriteM.
  - Otherwise 01 if (RA1E == WA3W) & RegWriteW.
  - Otherwise 00.
  - ForwardBE follows the same rule using RA2E.
  - Never forward when the source register is 4'hF (R15 is read as PC+8).
  - M has priority over W.
- Hazard terms:
  - LDRstall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E)).
  - MemStall = MemReqM & ~MemReadyM (combinational, so it takes effect on the first wait cycle).
- When MemStall = 1:
  - StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - FlushD = FlushE = 0. The pipeline is frozen and pending branch or PC hazards act on release.
- When MemStall = 0:
  - StallF = LDRstall | PCWrPendingF; StallD = LDRstall; StallE = StallM = FlushW = 0.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- Wait FSM states: IDLE and WAIT.
  - IDLE -> WAIT when MemStall = 1; on that edge WaitCnt = 1.
  - WAIT -> WAIT while MemStall = 1; WaitCnt increments and saturates at MAX_WAIT.
  - WAIT -> IDLE when MemReadyM = 1 or MemReqM = 0; WaitCnt = 0.
  - MemTimeout is set on the edge where WaitCnt would reach MAX_WAIT. It stays set until reset or CntClear.
- Counters:
  - StallCount increments on each cycle where StallD = 1 (load-use or memory stall).
  - FlushCount increments on each cycle where BranchTakenE & ~MemStall.
  - Both saturate at all-ones and never wrap.
  - CntClear has priority over increment in the same cycle.
- Reset (asynchronous, active-low, may assert mid-operation):
  - FSM returns to IDLE; WaitCnt, MemTimeout and both counters go to 0.
  - Combinational outputs follow their inputs during reset; with all inputs 0, every stall, flush and forward output is 0.
- Latency: all stall, flush and forward outputs are zero-latency combinational. Counters and MemTimeout update one cycle after the event.

Test Plan:
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> 01. Then RA1E=15 -> 00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0. StallCount increments by 1 on the next edge.
- BranchTakenE=1, no other hazards -> FlushD=FlushE=1, StallF=0. FlushCount increments by 1.
- MemReqM=1, MemReadyM=0 for 3 cycles, with BranchTakenE=1 held -> StallF/D/E/M=FlushW=1 and FlushD=FlushE=0 for those 3 cycles. MemReadyM=1 on cycle 4 -> FSM returns to IDLE and FlushD=FlushE=1.
- MemReqM=1, MemReadyM=0 for 10 cycles with MAX_WAIT=8 -> MemTimeout rises after the 8th wait cycle and stays set after MemReadyM=1. CntClear=1 clears it.
- With CNT_W=4, hold load-use for 20 cycles -> StallCount saturates at 15. Assert reset mid-stall -> all counters read 0 immediately; FSM is in IDLE after release.
